// File: rtl/debounce_edge.sv
`default_nettype none
// ============================================================================
// Module      : debounce_edge
// Description : Two-flop synchronizer followed by a four-state debounce FSM.
//               A level change is accepted only after STABLE_CYCLES
//               consecutive identical synchronized samples. Accepted changes
//               produce one-cycle rise/fall pulses. Candidate changes that
//               collapse early are counted in a saturating glitch counter.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_edge #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic             clr,
   output logic             level,
   output logic             rise,
   output logic             fall,
   output logic             busy,
   output logic [CNT_W-1:0] glitch_cnt
);

   // Qualification counter wide enough to hold STABLE_CYCLES
   localparam int RUN_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;

   localparam logic [RUN_W-1:0] c_run_zero = '0;
   localparam logic [RUN_W-1:0] c_run_one  = RUN_W'(1);
   localparam logic [RUN_W-1:0] c_run_last = RUN_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_cnt_max  = '1;
   localparam bit               c_single   = (STABLE_CYCLES == 1);

   typedef enum logic [1:0] {
      LOW      = 2'd0,
      CHK_HIGH = 2'd1,
      HIGH     = 2'd2,
      CHK_LOW  = 2'd3
   } state_t;

   logic             r_s1;
   logic             r_s2;
   logic             w_in_q;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [RUN_W-1:0] r_run_cnt;
   logic [RUN_W-1:0] w_run_nxt;
   logic             w_rise_nxt;
   logic             w_fall_nxt;
   logic             w_glitch_evt;

   assign w_in_q = r_s2;

   // Synchronize the asynchronous input before the FSM ever looks at it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= in;
         r_s2 <= r_s1;
      end
   end

   // Next-state, run counter and event decode
   always_comb begin
      w_state_nxt  = r_state;
      w_run_nxt    = r_run_cnt;
      w_rise_nxt   = 1'b0;
      w_fall_nxt   = 1'b0;
      w_glitch_evt = 1'b0;
      case (r_state)
         LOW: begin
            if (w_in_q) begin
               if (c_single) begin
                  w_state_nxt = HIGH;
                  w_run_nxt   = c_run_zero;
                  w_rise_nxt  = 1'b1;
               end else begin
                  w_state_nxt = CHK_HIGH;
                  w_run_nxt   = c_run_one;
               end
            end
         end
         CHK_HIGH: begin
            if (w_in_q) begin
               if (r_run_cnt == c_run_last) begin
                  w_state_nxt = HIGH;
                  w_run_nxt   = c_run_zero;
                  w_rise_nxt  = 1'b1;
               end else begin
                  w_run_nxt = r_run_cnt + 1'b1;
               end
            end else begin
               w_state_nxt  = LOW;
               w_run_nxt    = c_run_zero;
               w_glitch_evt = 1'b1;
            end
         end
         HIGH: begin
            if (!w_in_q) begin
               if (c_single) begin
                  w_state_nxt = LOW;
                  w_run_nxt   = c_run_zero;
                  w_fall_nxt  = 1'b1;
               end else begin
                  w_state_nxt = CHK_LOW;
                  w_run_nxt   = c_run_one;
               end
            end
         end
         CHK_LOW: begin
            if (!w_in_q) begin
               if (r_run_cnt == c_run_last) begin
                  w_state_nxt = LOW;
                  w_run_nxt   = c_run_zero;
                  w_fall_nxt  = 1'b1;
               end else begin
                  w_run_nxt = r_run_cnt + 1'b1;
               end
            end else begin
               w_state_nxt  = HIGH;
               w_run_nxt    = c_run_zero;
               w_glitch_evt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = LOW;
            w_run_nxt   = c_run_zero;
         end
      endcase
   end

   // State register with outputs registered from the next-state decode
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= LOW;
         r_run_cnt <= c_run_zero;
         level     <= 1'b0;
         rise      <= 1'b0;
         fall      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_run_cnt <= w_run_nxt;
         level     <= (w_state_nxt == HIGH) || (w_state_nxt == CHK_LOW);
         rise      <= w_rise_nxt;
         fall      <= w_fall_nxt;
         busy      <= (w_state_nxt == CHK_HIGH) || (w_state_nxt == CHK_LOW);
      end
   end

   // Saturating glitch counter; clear beats a coincident glitch
   always_ff @(posedge clk) begin
      if (rst) begin
         glitch_cnt <= '0;
      end else if (clr) begin
         glitch_cnt <= '0;
      end else if (w_glitch_evt && (glitch_cnt != c_cnt_max)) begin
         glitch_cnt <= glitch_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_debounce_edge.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_edge
// Description : Self-checking bench for debounce_edge. Three builds share one
//               stimulus stream: default, narrow glitch counter, and
//               single-sample qualification. A run-length reference model is
//               compared every cycle; directed scenarios pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_edge;

   logic       clk = 1'b0;
   logic       rst;
   logic       in;
   logic       clr;

   logic       level_a, rise_a, fall_a, busy_a;
   logic [7:0] glitch_a;
   logic       level_b, rise_b, fall_b, busy_b;
   logic [1:0] glitch_b;
   logic       level_c, rise_c, fall_c, busy_c;
   logic [7:0] glitch_c;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   debounce_edge dut_a (
      .clk(clk), .rst(rst), .in(in), .clr(clr),
      .level(level_a), .rise(rise_a), .fall(fall_a), .busy(busy_a),
      .glitch_cnt(glitch_a)
   );

   debounce_edge #(.STABLE_CYCLES(4), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .in(in), .clr(clr),
      .level(level_b), .rise(rise_b), .fall(fall_b), .busy(busy_b),
      .glitch_cnt(glitch_b)
   );

   debounce_edge #(.STABLE_CYCLES(1), .CNT_W(8)) dut_c (
      .clk(clk), .rst(rst), .in(in), .clr(clr),
      .level(level_c), .rise(rise_c), .fall(fall_c), .busy(busy_c),
      .glitch_cnt(glitch_c)
   );

   // Reference: the accepted level plus the length of the current run of
   // samples that disagree with it. A run reaching STABLE_CYCLES flips the
   // level; a run broken early is a glitch.
   typedef struct {
      int level;
      int rise;
      int fall;
      int busy;
      int glitch;
      int run;
   } mdl_t;

   mdl_t ma, mb, mc;
   int   d1, d2;
   bit   started = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic mstep(input int s, input int w, input int q, input bit c,
                        inout mdl_t m);
      bit evt;
      evt    = 1'b0;
      m.rise = 0;
      m.fall = 0;
      if (q != m.level) begin
         m.run++;
         if (m.run == s) begin
            if (q == 1) m.rise = 1; else m.fall = 1;
            m.level = q;
            m.run   = 0;
         end
      end else begin
         if (m.run > 0) evt = 1'b1;
         m.run = 0;
      end
      if (c) m.glitch = 0;
      else if (evt && m.glitch < (1 << w) - 1) m.glitch++;
      m.busy = (m.run > 0) ? 1 : 0;
   endtask

   function automatic mdl_t mzero();
      mdl_t z;
      z = '{default: 0};
      return z;
   endfunction

   // Advance the reference on every rising edge
   always @(posedge clk) begin
      if (rst) begin
         d1 = 0;
         d2 = 0;
         ma = mzero();
         mb = mzero();
         mc = mzero();
      end else begin
         mstep(4, 8, d2, clr, ma);
         mstep(4, 2, d2, clr, mb);
         mstep(1, 8, d2, clr, mc);
         d2 = d1;
         d1 = int'(in);
      end
      started = 1'b1;
   end

   bit busy_c_seen = 1'b0;

   // Compare all three builds against the reference just after each edge
   always @(posedge clk) begin
      #1;
      if (started) begin
         chk("a_level", level_a, ma.level);
         chk("a_rise", rise_a, ma.rise);
         chk("a_fall", fall_a, ma.fall);
         chk("a_busy", busy_a, ma.busy);
         chk("a_glitch", glitch_a, ma.glitch);
         chk("b_level", level_b, mb.level);
         chk("b_rise", rise_b, mb.rise);
         chk("b_fall", fall_b, mb.fall);
         chk("b_busy", busy_b, mb.busy);
         chk("b_glitch", glitch_b, mb.glitch);
         chk("c_level", level_c, mc.level);
         chk("c_rise", rise_c, mc.rise);
         chk("c_fall", fall_c, mc.fall);
         chk("c_busy", busy_c, mc.busy);
         chk("c_glitch", glitch_c, mc.glitch);
         if (rise_a && fall_a) chk("a_rise_fall_excl", 1, 0);
         if (busy_c) busy_c_seen = 1'b1;
      end
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Global time bound so the run can never hang
   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   int exp_sat[5] = '{1, 2, 3, 3, 3};
   int hold;
   logic cur;

   initial begin
      rst = 1'b1;
      in  = 1'b1;
      clr = 1'b0;

      // Reset held two edges with in=1, then release and qualify the rise
      wait_neg(2);
      chk("rst_level", level_a, 0);
      chk("rst_rise", rise_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_glitch", glitch_a, 0);
      rst = 1'b0;
      wait_neg(3);
      chk("c_rise_r2", rise_c, 1);
      chk("c_level_r2", level_c, 1);
      chk("a_busy_r2", busy_a, 1);
      chk("a_level_r2", level_a, 0);
      wait_neg(2);
      chk("a_level_r4", level_a, 0);
      chk("a_rise_r4", rise_a, 0);
      wait_neg(1);
      chk("a_level_r5", level_a, 1);
      chk("a_rise_r5", rise_a, 1);
      chk("model_rise_r5", ma.rise, 1);
      wait_neg(1);
      chk("a_rise_r6", rise_a, 0);
      chk("a_level_r6", level_a, 1);

      // Fall from HIGH
      in = 1'b0;
      wait_neg(5);
      chk("a_level_e4", level_a, 1);
      chk("a_fall_e4", fall_a, 0);
      wait_neg(1);
      chk("a_fall_e5", fall_a, 1);
      chk("a_level_e5", level_a, 0);
      chk("a_glitch_e5", glitch_a, 0);
      wait_neg(1);
      chk("a_fall_e6", fall_a, 0);
      wait_neg(3);

      // Two-cycle glitch from LOW
      in = 1'b1;
      wait_neg(2);
      in = 1'b0;
      wait_neg(1);
      chk("g_busy1", busy_a, 1);
      wait_neg(1);
      chk("g_busy2", busy_a, 1);
      wait_neg(1);
      chk("g_busy_end", busy_a, 0);
      chk("g_level", level_a, 0);
      chk("g_glitch", glitch_a, 1);
      chk("model_g_glitch", ma.glitch, 1);
      wait_neg(3);

      // Saturation of the two-bit counter
      clr = 1'b1;
      wait_neg(1);
      clr = 1'b0;
      chk("clr_b", glitch_b, 0);
      chk("clr_a", glitch_a, 0);
      for (int k = 0; k < 5; k++) begin
         in = 1'b1;
         wait_neg(1);
         in = 1'b0;
         wait_neg(4);
         chk("sat_b", glitch_b, exp_sat[k]);
      end
      chk("sat_a", glitch_a, 5);
      chk("sat_b_level", level_b, 0);

      // Reset while HIGH
      in = 1'b1;
      wait_neg(8);
      chk("mid_level_pre", level_a, 1);
      rst = 1'b1;
      wait_neg(1);
      chk("mid_level", level_a, 0);
      chk("mid_fall", fall_a, 0);
      chk("mid_glitch", glitch_a, 0);
      chk("mid_busy", busy_a, 0);
      rst = 1'b0;
      wait_neg(6);
      chk("mid_requal_level", level_a, 1);
      chk("mid_requal_rise", rise_a, 1);

      // Clear coincident with a glitch event
      in = 1'b0;
      wait_neg(8);
      for (int k = 0; k < 2; k++) begin
         in = 1'b1;
         wait_neg(1);
         in = 1'b0;
         wait_neg(4);
      end
      chk("pre_clr_glitch", glitch_a, 2);
      in = 1'b1;
      wait_neg(1);
      in = 1'b0;
      wait_neg(2);
      clr = 1'b1;
      wait_neg(1);
      clr = 1'b0;
      chk("clr_win_a", glitch_a, 0);
      chk("clr_win_b", glitch_b, 0);
      chk("clr_win_busy", busy_a, 0);

      // Randomized runs of varying length with occasional clr and rst
      hold = 0;
      cur  = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (hold == 0) begin
            cur  = $urandom_range(0, 1) == 1;
            hold = $urandom_range(1, 7);
         end
         hold--;
         in  = cur;
         clr = ($urandom_range(0, 49) == 0);
         rst = ($urandom_range(0, 299) == 0);
      end
      @(negedge clk);
      rst = 1'b0;
      clr = 1'b0;
      wait_neg(2);

      chk("c_busy_never", int'(busy_c_seen), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
